// File: rtl/alu_flag_ctrl_pkg.sv
// Shared types for the ALU flag controller: command encodings,
// flag indices, condition codes, pending-entry struct and helpers.
package alu_flag_ctrl_pkg;

    // Data-processing command field funct[4:1]
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_RSB = 4'b0011;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ADC = 4'b0101;
    localparam logic [3:0] CMD_SBC = 4'b0110;
    localparam logic [3:0] CMD_RSC = 4'b0111;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_TEQ = 4'b1001;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_CMN = 4'b1011;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;
    localparam logic [3:0] CMD_BIC = 4'b1110;
    localparam logic [3:0] CMD_MVN = 4'b1111;

    // NZCV bit positions
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Mask bit positions
    localparam int MASK_NZ = 1;
    localparam int MASK_CV = 0;

    // Condition field encodings
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    typedef struct packed {
        logic [1:0] mask;
        logic [3:0] nzcv;
    } pend_entry_t;

    typedef enum logic [1:0] {
        CLS_ARITH,
        CLS_LOGIC,
        CLS_TEST,
        CLS_ILLEGAL
    } cmd_cls_t;

    function automatic cmd_cls_t cmd_class(input logic [3:0] cmd);
        cmd_cls_t c;
        c = CLS_ILLEGAL;
        case (cmd)
            CMD_ADD, CMD_SUB, CMD_RSB,
            CMD_ADC, CMD_SBC:          c = CLS_ARITH;
            CMD_AND, CMD_EOR, CMD_ORR,
            CMD_MOV, CMD_BIC, CMD_MVN: c = CLS_LOGIC;
            CMD_TST, CMD_TEQ,
            CMD_CMP, CMD_CMN:          c = CLS_TEST;
            default:                   c = CLS_ILLEGAL;
        endcase
        return c;
    endfunction

    function automatic logic cond_eval(
        input logic [3:0] cond,
        input logic [3:0] f
    );
        logic n, z, c, v, r;
        n = f[FLAG_N];
        z = f[FLAG_Z];
        c = f[FLAG_C];
        v = f[FLAG_V];
        case (cond)
            COND_EQ: r = z;
            COND_NE: r = ~z;
            COND_CS: r = c;
            COND_CC: r = ~c;
            COND_MI: r = n;
            COND_PL: r = ~n;
            COND_VS: r = v;
            COND_VC: r = ~v;
            COND_HI: r = c & ~z;
            COND_LS: r = ~c | z;
            COND_GE: r = (n == v);
            COND_LT: r = (n != v);
            COND_GT: r = ~z & (n == v);
            COND_LE: r = z | (n != v);
            // NV is treated as always
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    // Merge an entry's flags into the current NZCV under its mask
    function automatic logic [3:0] flags_apply(
        input logic [3:0]  cur,
        input pend_entry_t e
    );
        logic [3:0] r;
        r = cur;
        if (e.mask[MASK_NZ]) begin
            r[FLAG_N] = e.nzcv[FLAG_N];
            r[FLAG_Z] = e.nzcv[FLAG_Z];
        end
        if (e.mask[MASK_CV]) begin
            r[FLAG_C] = e.nzcv[FLAG_C];
            r[FLAG_V] = e.nzcv[FLAG_V];
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_flag_ctrl_if.sv
// Bundle between microsequencer/ALU (master) and flag controller (slave).
// Carries decode inputs, flag updates, commit/flush and all results.
interface alu_flag_ctrl_if;

    logic       alu_op;
    logic [4:0] funct;
    logic [3:0] cond;
    logic       alu_valid;
    logic [3:0] alu_flags;
    logic       commit;
    logic       flush;

    logic [1:0] flag_w;
    logic       no_reg_w;
    logic       reg_w_ok;
    logic       cond_met;
    logic       illegal;
    logic [3:0] flags_q;
    logic [2:0] pend_cnt;
    logic       full;

    modport master (
        output alu_op, funct, cond, alu_valid,
        output alu_flags, commit, flush,
        input  flag_w, no_reg_w, reg_w_ok, cond_met,
        input  illegal, flags_q, pend_cnt, full
    );

    modport slave (
        input  alu_op, funct, cond, alu_valid,
        input  alu_flags, commit, flush,
        output flag_w, no_reg_w, reg_w_ok, cond_met,
        output illegal, flags_q, pend_cnt, full
    );

endinterface

// File: rtl/alu_flag_ctrl_flag_pend_fifo.sv
// Small circular FIFO of pending flag updates (1..4 entries).
// Ports: push/pop/clear controls, din/dout entry, count and full status.
module flag_pend_fifo
    import alu_flag_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        push,
    input  logic        pop,
    input  logic        clear,
    input  pend_entry_t din,
    output pend_entry_t dout,
    output logic [2:0]  count,
    output logic        full
);

    localparam logic [2:0] DEPTH_C = 3'(DEPTH);
    localparam logic [1:0] LAST    = 2'(DEPTH - 1);

    // Storage is sized for the maximum depth so 2-bit pointers index cleanly
    pend_entry_t mem_q [4];
    pend_entry_t mem_d [4];
    logic [1:0]  wr_q, wr_d;
    logic [1:0]  rd_q, rd_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        do_push;
    logic        do_pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == LAST) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        do_pop  = pop && (cnt_q != 3'd0);
        // A push into a full queue only fits if the head leaves this cycle
        do_push = push && ((cnt_q < DEPTH_C) || do_pop);
        if (clear) begin
            wr_d  = 2'd0;
            rd_d  = 2'd0;
            cnt_d = 3'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = din;
                wr_d        = ptr_inc(wr_q);
            end
            if (do_pop) begin
                rd_d = ptr_inc(rd_q);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 3'd1;
                2'b01:   cnt_d = cnt_q - 3'd1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= 2'd0;
            rd_q  <= 2'd0;
            cnt_q <= 3'd0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout  = mem_q[rd_q];
    assign count = cnt_q;
    assign full  = (cnt_q == DEPTH_C);

endmodule

// File: rtl/alu_flag_ctrl.sv
// ALU flag controller: decodes data-processing commands into flag masks,
// evaluates cond on NZCV and retires buffered flag updates on commit.
// Ports: clk, reset_n (async, active low), bus (slave modport).
module alu_flag_ctrl
    import alu_flag_ctrl_pkg::*;
#(
    parameter int PEND_DEPTH  = 2,
    parameter bit COMMIT_MODE = 1'b1
) (
    input logic           clk,
    input logic           reset_n,
    alu_flag_ctrl_if.slave bus
);

    cmd_cls_t    cls;
    logic        s_bit;
    logic [1:0]  raw_mask;
    logic        no_reg_w;
    logic        illegal;
    logic        cond_met;
    logic [1:0]  flag_w;
    logic        upd_req;
    logic        head_apply;
    logic [3:0]  flags_q, flags_d;
    pend_entry_t new_ent;
    pend_entry_t head_ent;
    logic [2:0]  fifo_cnt;
    logic        fifo_full;

    // Command decode
    always_comb begin
        raw_mask = 2'b00;
        no_reg_w = 1'b0;
        illegal  = 1'b0;
        cls      = cmd_class(bus.funct[4:1]);
        s_bit    = bus.funct[0];
        if (bus.alu_op) begin
            unique case (1'b1)
                (cls == CLS_ARITH): begin
                    raw_mask = {2{s_bit}};
                end
                (cls == CLS_LOGIC): begin
                    raw_mask = {s_bit, 1'b0};
                end
                (cls == CLS_TEST): begin
                    // Compares always write flags, tests only N,Z
                    raw_mask = (bus.funct[4:1] == CMD_CMP ||
                                bus.funct[4:1] == CMD_CMN)
                             ? 2'b11 : 2'b10;
                    no_reg_w = 1'b1;
                end
                (cls == CLS_ILLEGAL): begin
                    illegal = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // No forwarding from pending entries: cond sees retired flags only
    assign cond_met = cond_eval(bus.cond, flags_q);
    assign flag_w   = raw_mask & {2{cond_met}};
    assign upd_req  = bus.alu_valid & bus.alu_op & (|flag_w);

    always_comb begin
        new_ent      = '0;
        new_ent.mask = flag_w;
        new_ent.nzcv = bus.alu_flags;
    end

    flag_pend_fifo #(
        .DEPTH (PEND_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (COMMIT_MODE && upd_req),
        .pop     (COMMIT_MODE && bus.commit),
        .clear   (COMMIT_MODE && bus.flush),
        .din     (new_ent),
        .dout    (head_ent),
        .count   (fifo_cnt),
        .full    (fifo_full)
    );

    // Flush wins over commit, so the head is not retired on a flush cycle
    assign head_apply = COMMIT_MODE && bus.commit && !bus.flush &&
                        (fifo_cnt != 3'd0);

    always_comb begin
        flags_d = flags_q;
        if (COMMIT_MODE) begin
            if (head_apply) begin
                flags_d = flags_apply(flags_q, head_ent);
            end
        end else begin
            if (upd_req) begin
                flags_d = flags_apply(flags_q, new_ent);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign bus.flag_w   = flag_w;
    assign bus.no_reg_w = no_reg_w;
    assign bus.illegal  = illegal;
    assign bus.cond_met = cond_met;
    assign bus.reg_w_ok = bus.alu_op & cond_met & ~no_reg_w & ~illegal;
    assign bus.flags_q  = flags_q;
    assign bus.pend_cnt = fifo_cnt;
    assign bus.full     = fifo_full;

endmodule

// File: tb/tb_alu_flag_ctrl.sv
// Directed bench for alu_flag_ctrl with a pending-entry scoreboard.
// Checks decode, cond, queue depth, flush, async reset and bypass mode.
module tb_alu_flag_ctrl;

    typedef struct {
        logic [1:0] m;
        logic [3:0] f;
    } tb_ent_t;

    localparam int DEPTH = 2;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    tb_ent_t    sb[$];
    logic [3:0] model_flags;
    logic [1:0] exp_mask;

    alu_flag_ctrl_if bus ();
    alu_flag_ctrl_if bus0 ();

    alu_flag_ctrl #(
        .PEND_DEPTH  (DEPTH),
        .COMMIT_MODE (1'b1)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    alu_flag_ctrl #(
        .PEND_DEPTH  (DEPTH),
        .COMMIT_MODE (1'b0)
    ) u_dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(
        input string      tag,
        input logic [7:0] obs,
        input logic [7:0] exp
    );
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic op(
        input logic [4:0] f,
        input logic [3:0] c,
        input logic [3:0] fl,
        input logic       v
    );
        bus.alu_op    = 1'b1;
        bus.funct     = f;
        bus.cond      = c;
        bus.alu_flags = fl;
        bus.alu_valid = v;
    endtask

    // Update the scoreboard for this edge, clock, then check queue state
    task automatic clk_edge(input string tag);
        tb_ent_t h;
        bit      pop;
        bit      push_ok;
        push_ok = bus.alu_valid && bus.alu_op && (exp_mask != 2'b00);
        if (bus.flush) begin
            sb.delete();
        end else begin
            pop = bus.commit && (sb.size() > 0);
            if (pop) begin
                h = sb.pop_front();
                if (h.m[1]) model_flags[3:2] = h.f[3:2];
                if (h.m[0]) model_flags[1:0] = h.f[1:0];
            end
            if (push_ok && sb.size() < DEPTH) begin
                h.m = exp_mask;
                h.f = bus.alu_flags;
                sb.push_back(h);
            end
        end
        @(posedge clk);
        #1;
        chk({tag, ".flags"}, 8'(bus.flags_q), 8'(model_flags));
        chk({tag, ".cnt"}, 8'(bus.pend_cnt), 8'(sb.size()));
        chk({tag, ".full"}, 8'(bus.full), 8'(sb.size() == DEPTH));
    endtask

    task automatic idle();
        bus.alu_op    = 1'b0;
        bus.alu_valid = 1'b0;
        bus.commit    = 1'b0;
        bus.flush     = 1'b0;
        exp_mask      = 2'b00;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        model_flags = 4'b0000;
        exp_mask    = 2'b00;
        reset_n     = 1'b0;
        bus.alu_op = 0; bus.funct = 0; bus.cond = 4'b1110;
        bus.alu_valid = 0; bus.alu_flags = 0;
        bus.commit = 0; bus.flush = 0;
        bus0.alu_op = 0; bus0.funct = 0; bus0.cond = 4'b1110;
        bus0.alu_valid = 0; bus0.alu_flags = 0;
        bus0.commit = 0; bus0.flush = 0;

        #12;
        chk("rst.flags", 8'(bus.flags_q), 8'h0);
        chk("rst.cnt", 8'(bus.pend_cnt), 8'h0);
        chk("rst.full", 8'(bus.full), 8'h0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // SUBS, AL, then commit
        op(5'b00101, 4'b1110, 4'b0110, 1'b1);
        exp_mask = 2'b11;
        #1;
        chk("subs.fw", 8'(bus.flag_w), 8'h3);
        chk("subs.nrw", 8'(bus.no_reg_w), 8'h0);
        chk("subs.rwok", 8'(bus.reg_w_ok), 8'h1);
        chk("subs.ill", 8'(bus.illegal), 8'h0);
        clk_edge("subs.push");
        chk("subs.cnt1", 8'(bus.pend_cnt), 8'h1);
        idle();
        bus.commit = 1'b1;
        clk_edge("subs.cmt");
        chk("subs.res", 8'(bus.flags_q), 8'h6);
        chk("subs.cnt0", 8'(bus.pend_cnt), 8'h0);

        // ADDS to set flags 0001
        idle();
        op(5'b01001, 4'b1110, 4'b0001, 1'b1);
        exp_mask = 2'b11;
        clk_edge("adds.push");
        idle();
        bus.commit = 1'b1;
        clk_edge("adds.cmt");

        // ORRS keeps C,V
        idle();
        op(5'b11001, 4'b1110, 4'b1011, 1'b1);
        exp_mask = 2'b10;
        #1;
        chk("orrs.fw", 8'(bus.flag_w), 8'h2);
        clk_edge("orrs.push");
        idle();
        bus.commit = 1'b1;
        clk_edge("orrs.cmt");
        chk("orrs.res", 8'(bus.flags_q), 8'h9);

        // CMP S=0 with cond EQ failing (Z=0)
        idle();
        op(5'b10100, 4'b0000, 4'b0100, 1'b1);
        exp_mask = 2'b00;
        #1;
        chk("cmp.cm", 8'(bus.cond_met), 8'h0);
        chk("cmp.fw", 8'(bus.flag_w), 8'h0);
        chk("cmp.nrw", 8'(bus.no_reg_w), 8'h1);
        chk("cmp.rwok", 8'(bus.reg_w_ok), 8'h0);
        clk_edge("cmp.edge");

        // Depth: three pushes, third dropped
        idle();
        op(5'b01001, 4'b1110, 4'b0100, 1'b1);
        exp_mask = 2'b11;
        clk_edge("dep.p1");
        bus.alu_flags = 4'b0010;
        clk_edge("dep.p2");
        chk("dep.full2", 8'(bus.full), 8'h1);
        bus.alu_flags = 4'b1111;
        clk_edge("dep.p3");
        chk("dep.cnt3", 8'(bus.pend_cnt), 8'h2);
        // push + commit while full
        bus.alu_flags = 4'b0011;
        bus.commit    = 1'b1;
        clk_edge("dep.pc");
        chk("dep.pc.fl", 8'(bus.flags_q), 8'h4);
        chk("dep.pc.cnt", 8'(bus.pend_cnt), 8'h2);
        // flush + commit
        idle();
        bus.flush  = 1'b1;
        bus.commit = 1'b1;
        clk_edge("dep.fl");
        chk("dep.fl.fl", 8'(bus.flags_q), 8'h4);
        chk("dep.fl.cnt", 8'(bus.pend_cnt), 8'h0);

        // Commit on empty queue is a no-op
        idle();
        bus.commit = 1'b1;
        clk_edge("empty.cmt");

        // Reset mid-queue
        idle();
        op(5'b01001, 4'b1110, 4'b1100, 1'b1);
        exp_mask = 2'b11;
        clk_edge("mid.p1");
        bus.alu_flags = 4'b0001;
        clk_edge("mid.p2");
        idle();
        bus.commit = 1'b1;
        clk_edge("mid.c1");
        chk("mid.fl", 8'(bus.flags_q), 8'hc);
        idle();
        op(5'b01001, 4'b1110, 4'b0111, 1'b1);
        exp_mask = 2'b11;
        clk_edge("mid.p3");
        chk("mid.cnt2", 8'(bus.pend_cnt), 8'h2);
        idle();
        reset_n = 1'b0;
        #1;
        chk("arst.flags", 8'(bus.flags_q), 8'h0);
        chk("arst.cnt", 8'(bus.pend_cnt), 8'h0);
        chk("arst.full", 8'(bus.full), 8'h0);
        sb.delete();
        model_flags = 4'b0000;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Condition table against NZCV = 0000
        bus.cond = 4'b0000; #1; chk("c0.eq", 8'(bus.cond_met), 8'h0);
        bus.cond = 4'b0001; #1; chk("c0.ne", 8'(bus.cond_met), 8'h1);
        bus.cond = 4'b1010; #1; chk("c0.ge", 8'(bus.cond_met), 8'h1);
        bus.cond = 4'b1000; #1; chk("c0.hi", 8'(bus.cond_met), 8'h0);
        bus.cond = 4'b1001; #1; chk("c0.ls", 8'(bus.cond_met), 8'h1);
        bus.cond = 4'b1111; #1; chk("c0.nv", 8'(bus.cond_met), 8'h1);

        // Set N only, then signed conditions
        op(5'b01001, 4'b1110, 4'b1000, 1'b1);
        exp_mask = 2'b11;
        clk_edge("n.push");
        idle();
        bus.commit = 1'b1;
        clk_edge("n.cmt");
        idle();
        bus.cond = 4'b0100; #1; chk("cn.mi", 8'(bus.cond_met), 8'h1);
        bus.cond = 4'b1010; #1; chk("cn.ge", 8'(bus.cond_met), 8'h0);
        bus.cond = 4'b1011; #1; chk("cn.lt", 8'(bus.cond_met), 8'h1);
        bus.cond = 4'b1101; #1; chk("cn.le", 8'(bus.cond_met), 8'h1);
        bus.cond = 4'b1100; #1; chk("cn.gt", 8'(bus.cond_met), 8'h0);

        // RSC is illegal and never enqueues
        op(5'b01111, 4'b1110, 4'b1111, 1'b1);
        exp_mask = 2'b00;
        #1;
        chk("rsc.ill", 8'(bus.illegal), 8'h1);
        chk("rsc.fw", 8'(bus.flag_w), 8'h0);
        chk("rsc.nrw", 8'(bus.no_reg_w), 8'h0);
        chk("rsc.rwok", 8'(bus.reg_w_ok), 8'h0);
        clk_edge("rsc.edge");

        // alu_op low idles decode outputs
        idle();
        bus.funct = 5'b10101;
        #1;
        chk("idle.ill", 8'(bus.illegal), 8'h0);
        chk("idle.fw", 8'(bus.flag_w), 8'h0);
        chk("idle.nrw", 8'(bus.no_reg_w), 8'h0);
        chk("idle.rwok", 8'(bus.reg_w_ok), 8'h0);

        // Bypass mode: ADDS writes flags at the edge
        chk("byp.pre", 8'(bus0.flags_q), 8'h0);
        bus0.alu_op    = 1'b1;
        bus0.funct     = 5'b01001;
        bus0.cond      = 4'b1110;
        bus0.alu_flags = 4'b1000;
        bus0.alu_valid = 1'b1;
        bus0.commit    = 1'b1;
        bus0.flush     = 1'b1;
        @(posedge clk);
        #1;
        chk("byp.flags", 8'(bus0.flags_q), 8'h8);
        chk("byp.cnt", 8'(bus0.pend_cnt), 8'h0);
        chk("byp.full", 8'(bus0.full), 8'h0);
        bus0.alu_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_flag_ctrl.md
Name: alu_flag_ctrl

Overview:
Next-generation ALU decoder for the microprogrammed ARM-subset core. It decodes the full data-processing command set into flag-write masks and a register-write suppress, and evaluates the 4-bit condition field against architectural NZCV. It buffers flag updates in a small queue until the microsequencer issues a commit strobe, so multi-cycle execute states write flags only on retirement. The block sits between the control-unit microcode ROM, the ALU and the register-file write enable.

Parameters:
PEND_DEPTH, 2, number of pending flag-update entries (1..4)
COMMIT_MODE, 1, 1 = flags applied on commit; 0 = applied at the clock edge of alu_valid (queue bypassed)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
alu_op  in  1  data-processing instruction in execute (else decode outputs idle)
funct  in  5  [4:1] cmd, [0] S bit
cond  in  4  ARM condition field
alu_valid  in  1  ALU result and alu_flags valid this cycle
alu_flags  in  4  {N,Z,C,V} from ALU
commit  in  1  retire oldest pending entry
flush  in  1  discard all pending entries
flag_w  out  2  effective mask: [1]=N,Z; [0]=C,V
no_reg_w  out  1  suppress register write (test/compare)
reg_w_ok  out  1  alu_op & cond_met & ~no_reg_w & ~illegal
cond_met  out  1  cond true against flags_q
illegal  out  1  unsupported cmd while alu_op
flags_q  out  4  architectural NZCV
pend_cnt  out  3  occupied entries
full  out  1  pend_cnt == PEND_DEPTH (microcode stalls)

Behaviour:
- Reset (async, reset_n low): flags_q=0000, queue emptied, pend_cnt=0, full=0. Combinational outputs follow their inputs.
- Decode (combinational, alu_op=1):
  - Arithmetic ADD 0100, SUB 0010, RSB 0011, ADC 0101, SBC 0110: raw mask = S ? 11 : 00.
  - Logical AND 0000, EOR 0001, ORR 1100, MOV 1101, BIC 1110, MVN 1111: raw mask = S ? 10 : 00.
  - CMP 1010, CMN 1011: raw mask 11. TST 1000, TEQ 1001: raw mask 10. All four force no_reg_w=1 regardless of S.
  - RSC 0111 is illegal=1: raw mask 00, no_reg_w=0.
  - flag_w = raw & {2{cond_met}}.
  - alu_op=0: flag_w=00, no_reg_w=0, illegal=0, reg_w_ok=0.
- Condition: standard ARM table (EQ..AL) on flags_q. cond 1111 is treated as AL. No forwarding from pending entries; microcode must commit before the next conditional instruction that depends on those flags.
- Enqueue (COMMIT_MODE=1): at the rising edge with alu_valid & alu_op & flag_w!=00 & ~full, push {mask, alu_flags}. A push while full is dropped, and illegal is not affected.
- Commit: at the edge with commit & pend_cnt>0, pop the oldest entry and apply masked bits: N,Z if mask[1]; C,V if mask[0]. Commit on an empty queue is a no-op.
- Simultaneous push and commit: the pop applies the old head, the push appends, pend_cnt is unchanged. This is legal even when full.
- flush: clears the queue at the edge and has priority over push and commit in the same cycle; flags_q is unchanged.
- COMMIT_MODE=0: a qualifying alu_valid updates flags_q directly at that edge. pend_cnt=0 and full=0 always; commit and flush are ignored.
- Pointers wrap modulo PEND_DEPTH. pend_cnt never exceeds PEND_DEPTH.

Decomposition:
- alu_flag_pkg: cmd encodings (localparams), flag-bit indices, cond encodings, the pend_entry_t struct {mask[1:0], nzcv[3:0]}.
- One sub-module, flag_pend_fifo: a PEND_DEPTH-entry FIFO with push, pop, clear, count and full. The top holds the decode, cond_met and flags_q registers.

Test Plan:
- Reset mid-queue: 2 entries pending, pulse reset_n low -> flags_q=0000, pend_cnt=0, full=0 immediately (async).
- SUBS (funct=00101), cond=AL, alu_flags=0110, alu_valid, then commit next cycle -> flag_w=11, pend_cnt 1 then 0, flags_q=0110.
- ORRS (11001), alu_flags=1011 over flags_q=0001 -> mask 10, after commit flags_q=1001 (C,V kept).
- CMP with S=0 (10100), cond=EQ with Z=0 -> cond_met=0, flag_w=00, no_reg_w=1, reg_w_ok=0, nothing enqueued.
- Depth: three pushes with PEND_DEPTH=2 and no commit -> third dropped, full=1. Then push+commit in the same cycle -> pend_cnt stays 2, first entry applied. Then flush+commit -> pend_cnt=0, flags_q unchanged by the flush cycle.
- RSC (01111) -> illegal=1, flag_w=00. With COMMIT_MODE=0, ADDS with alu_flags=1000 -> flags_q=1000 at the next edge, pend_cnt=0.
